mlp_stream_host: RTL

MLP_STREAM_HOST -- requirements
Module: mlp_stream_host

---
 rtl/mlp_stream_host_if.sv | 67 ++++++
 rtl/mlp_stream_host.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mlp_stream_host_if.sv
// Bundles the job control, input word stream, accelerator vector ports and
// result word stream of the MLP stream host into one connection.
// master: the host side (mlp_stream_host); slave: the surrounding environment.
//
// Ports (host view): start/cfg_num_samples in, busy/done/samples_done out,
// src_* word input, acc_pos/acc_dir/acc_in_* vector issue, acc_out/acc_out_*
// result capture, res_* result word output.
interface mlp_stream_host_if #(
  parameter int IN_WIDTH   = 32,
  parameter int POS_DIM    = 63,
  parameter int DIR_DIM    = 27,
  parameter int OUT_DIM    = 4,
  parameter int SAMPLE_CNT = 65536
);
  localparam int CW = $clog2(SAMPLE_CNT + 1);

  // job control
  logic                               start;
  logic [CW-1:0]                      cfg_num_samples;
  logic                               busy;
  logic                               done;
  logic [CW-1:0]                      samples_done;
  // input word stream
  logic [IN_WIDTH-1:0]                src_data;
  logic                               src_valid;
  logic                               src_ready;
  // vector issue to accelerator
  logic [POS_DIM-1:0][IN_WIDTH-1:0]   acc_pos;
  logic [DIR_DIM-1:0][IN_WIDTH-1:0]   acc_dir;
  logic                               acc_in_valid;
  logic                               acc_in_ready;
  // accelerator result
  logic [OUT_DIM-1:0][IN_WIDTH-1:0]   acc_out;
  logic                               acc_out_valid;
  logic                               acc_out_ready;
  // result word stream
  logic [IN_WIDTH-1:0]                res_data;
  logic                               res_valid;
  logic                               res_ready;
  logic                               res_last;

  modport master (
    input  start, cfg_num_samples,
    output busy, done, samples_done,
    input  src_data, src_valid,
    output src_ready,
    output acc_pos, acc_dir, acc_in_valid,
    input  acc_in_ready,
    input  acc_out, acc_out_valid,
    output acc_out_ready,
    output res_data, res_valid, res_last,
    input  res_ready
  );

  modport slave (
    output start, cfg_num_samples,
    input  busy, done, samples_done,
    output src_data, src_valid,
    input  src_ready,
    input  acc_pos, acc_dir, acc_in_valid,
    output acc_in_ready,
    output acc_out, acc_out_valid,
    input  acc_out_ready,
    input  res_data, res_valid, res_last,
    output res_ready
  );
endinterface

// File: rtl/mlp_stream_host.sv
// Purpose: gathers per-sample encoded pos/dir words, issues them as vectors to an MLP accelerator, streams results back out.
// Latency: POS_DIM+DIR_DIM load cycles, 1 issue, >=1 wait, 1 capture, OUT_DIM drain cycles per sample (plus stalls).
// Backpressure: every handshake (src, acc_in, acc_out, res) stalls the job indefinitely with all state held.
//
// Ports: clk, rst_n (async active-low); bus (mlp_stream_host_if.master) carrying
// start/cfg_num_samples -> busy/done/samples_done, src_* words in, acc_pos/acc_dir
// vector out with acc_in_* handshake, acc_out result in with acc_out_* handshake,
// res_* result words out with res_last on the job's final word.
module mlp_stream_host #(
  parameter int IN_WIDTH   = 32,
  parameter int POS_DIM    = 63,
  parameter int DIR_DIM    = 27,
  parameter int OUT_DIM    = 4,
  parameter int SAMPLE_CNT = 65536
) (
  input logic               clk,
  input logic               rst_n,
  mlp_stream_host_if.master bus
);
  localparam int CW  = $clog2(SAMPLE_CNT + 1);
  localparam int WPS = POS_DIM + DIR_DIM;                    // words per sample
  localparam int WW  = (WPS > 1) ? $clog2(WPS) : 1;
  localparam int DW  = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam logic [WW-1:0] LAST_WORD = WW'(WPS - 1);
  localparam logic [DW-1:0] LAST_RES  = DW'(OUT_DIM - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, ISSUE, WAIT_OUT, CAPTURE, DRAIN, DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]                    num_q;          // latched job sample count
  logic [CW-1:0]                    samples_done_q;
  logic [WW-1:0]                    word_idx_q;
  logic [DW-1:0]                    drain_idx_q;
  logic [POS_DIM-1:0][IN_WIDTH-1:0] pos_q;
  logic [DIR_DIM-1:0][IN_WIDTH-1:0] dir_q;
  logic [OUT_DIM-1:0][IN_WIDTH-1:0] res_q;
  logic [IN_WIDTH-1:0]              res_word;

  logic src_hs, in_hs, out_hs, res_hs;
  logic word_last, res_idx_last, last_sample;

  assign src_hs = (state_q == LOAD)     && bus.src_valid;
  assign in_hs  = (state_q == ISSUE)    && bus.acc_in_ready;
  assign out_hs = (state_q == WAIT_OUT) && bus.acc_out_valid;
  assign res_hs = (state_q == DRAIN)    && bus.res_ready;

  assign word_last    = (word_idx_q == LAST_WORD);
  assign res_idx_last = (drain_idx_q == LAST_RES);
  // samples_done never reaches num_q while a sample is in flight, so +1 cannot wrap.
  assign last_sample  = ((samples_done_q + CW'(1)) == num_q);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (bus.cfg_num_samples == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (src_hs && word_last) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (in_hs) begin
          state_d = WAIT_OUT;
        end
      end
      WAIT_OUT: begin
        if (out_hs) begin
          state_d = CAPTURE;
        end
      end
      // The accelerator presents its result the cycle after the out handshake.
      CAPTURE: state_d = DRAIN;
      DRAIN: begin
        if (res_hs && res_idx_last) begin
          state_d = last_sample ? DONE : LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q          <= '0;
      samples_done_q <= '0;
      word_idx_q     <= '0;
      drain_idx_q    <= '0;
      pos_q          <= '0;
      dir_q          <= '0;
      res_q          <= '0;
    end else begin
      if ((state_q == IDLE) && bus.start) begin
        num_q          <= bus.cfg_num_samples;
        samples_done_q <= '0;
      end

      // Word slots 0..POS_DIM-1 fill the position vector, the rest the direction vector.
      if (src_hs) begin
        for (int i = 0; i < POS_DIM; i++) begin
          if (word_idx_q == WW'(i)) begin
            pos_q[i] <= bus.src_data;
          end
        end
        for (int j = 0; j < DIR_DIM; j++) begin
          if (word_idx_q == WW'(POS_DIM + j)) begin
            dir_q[j] <= bus.src_data;
          end
        end
        word_idx_q <= word_last ? '0 : word_idx_q + WW'(1);
      end

      if (state_q == CAPTURE) begin
        res_q <= bus.acc_out;
      end

      if (res_hs) begin
        drain_idx_q <= res_idx_last ? '0 : drain_idx_q + DW'(1);
        if (res_idx_last) begin
          samples_done_q <= samples_done_q + CW'(1);
        end
      end
    end
  end

  // Result word select; indices beyond OUT_DIM-1 are unreachable and read as 0.
  always_comb begin
    res_word = '0;
    for (int k = 0; k < OUT_DIM; k++) begin
      if (drain_idx_q == DW'(k)) begin
        res_word = res_q[k];
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = (state_q == DONE);
  assign bus.samples_done  = samples_done_q;
  assign bus.src_ready     = (state_q == LOAD);
  assign bus.acc_pos       = pos_q;
  assign bus.acc_dir       = dir_q;
  assign bus.acc_in_valid  = (state_q == ISSUE);
  assign bus.acc_out_ready = (state_q == WAIT_OUT);
  assign bus.res_data      = res_word;
  assign bus.res_valid     = (state_q == DRAIN);
  assign bus.res_last      = (state_q == DRAIN) && res_idx_last && last_sample;

endmodule
